// File: rtl/vending_machine_core_pkg.sv
`default_nettype none
// ============================================================================
// Package : vm_pkg
// Brief   : Key codes, coin/price tables, credit limit, segment patterns and
//           BCD/segment helper functions for vending_machine_core.
// Revision: 1.0 - initial release
// ============================================================================
package vm_pkg;

  localparam logic [3:0] KEY_COIN5   = 4'd0;
  localparam logic [3:0] KEY_COIN10  = 4'd1;
  localparam logic [3:0] KEY_COIN25  = 4'd2;
  localparam logic [3:0] KEY_COIN100 = 4'd3;
  localparam logic [3:0] KEY_ITEM0   = 4'd4;
  localparam logic [3:0] KEY_ITEM7   = 4'd11;
  localparam logic [3:0] KEY_CANCEL  = 4'd12;

  localparam logic [9:0] CREDIT_MAX = 10'd999;

  localparam logic [9:0] COIN_VALUE [4] = '{10'd5, 10'd10, 10'd25, 10'd100};
  localparam logic [9:0] ITEM_PRICE [8] = '{10'd25,  10'd50,  10'd75,  10'd100,
                                            10'd125, 10'd150, 10'd175, 10'd200};

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Position of the single low bit of an active-low one-hot line group
  function automatic logic [1:0] low_idx(input logic [3:0] n);
    case (n)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  endfunction

  // {hundreds, tens, units}; input is never above CREDIT_MAX
  function automatic logic [11:0] bin_to_bcd(input logic [9:0] v);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
    h = 4'(v / 10'd100);
    t = 4'((v % 10'd100) / 10'd10);
    u = 4'(v % 10'd10);
    bin_to_bcd = {h, t, u};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vending_machine_core_kpd_debounce.sv
`default_nettype none
// ============================================================================
// Module  : kpd_debounce
// Brief   : 4x4 active-low keypad decoder with stability counter; emits one
//           press pulse per stable key, no auto-repeat.
// Revision: 1.0 - initial release
// ============================================================================
module kpd_debounce
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_row,
  input  logic [3:0] i_col,
  output logic [3:0] o_code,
  output logic       o_press
);

  localparam logic [7:0] c_target = 8'(DEBOUNCE_CYCLES);

  logic       w_valid;
  logic [3:0] w_code;
  logic       w_same;
  logic [7:0] w_cnt_next;
  logic       w_fire;

  logic       r_valid;
  logic [3:0] r_code;
  logic [7:0] r_cnt;
  logic       r_press;

  assign w_valid = $onehot(~i_row) && $onehot(~i_col);
  assign w_code  = {low_idx(i_col), low_idx(i_row)};
  assign w_same  = w_valid && r_valid && (w_code == r_code);

  // Counter saturates at the target; the fire condition excludes the
  // saturated hold so a held key never repeats.
  always_comb begin
    w_cnt_next = 8'd0;
    if (!w_valid) begin
      w_cnt_next = 8'd0;
    end else if (w_same) begin
      w_cnt_next = (r_cnt == c_target) ? r_cnt : r_cnt + 8'd1;
    end else begin
      w_cnt_next = 8'd1;
    end
    w_fire = (w_cnt_next == c_target) && !(w_same && (r_cnt == c_target));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_code  <= 4'd0;
      r_cnt   <= 8'd0;
      r_press <= 1'b0;
    end else begin
      r_valid <= w_valid;
      r_code  <= w_code;
      r_cnt   <= w_cnt_next;
      r_press <= w_fire;
    end
  end

  assign o_code  = r_code;
  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/vending_machine_core.sv
`default_nettype none
// ============================================================================
// Module  : vending_machine_core
// Brief   : Keypad-driven credit/vend controller with 3-digit 7-seg display.
//           Optional macro VM_BLANK_ZERO_EN enables leading-zero blanking.
// Revision: 1.0 - initial release
// ============================================================================
module vending_machine_core
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic [3:0] shift_col,
  output logic [6:0] D0,
  output logic [6:0] D1,
  output logic [6:0] D2,
  output logic [3:0] debounced
);

  logic [3:0]  w_code;
  logic        w_press;
  logic [9:0]  w_credit_next;
  logic [9:0]  w_headroom;
  logic [9:0]  w_coin;
  logic [2:0]  w_item_idx;
  logic [9:0]  w_price;
  logic [11:0] w_bcd;

  logic [9:0]  r_credit;
  logic [3:0]  r_debounced;

  kpd_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_kpd_debounce (
    .clk    (clk),
    .reset  (reset),
    .i_row  (row),
    .i_col  (shift_col),
    .o_code (w_code),
    .o_press(w_press)
  );

  assign w_headroom = CREDIT_MAX - r_credit;
  assign w_coin     = COIN_VALUE[w_code[1:0]];
  assign w_item_idx = 3'(w_code - KEY_ITEM0);
  assign w_price    = ITEM_PRICE[w_item_idx];

  // Coin rejection compares against headroom so no wider adder is needed
  always_comb begin
    w_credit_next = r_credit;
    if (w_code <= KEY_COIN100) begin
      if (w_coin <= w_headroom) begin
        w_credit_next = r_credit + w_coin;
      end
    end else if (w_code <= KEY_ITEM7) begin
      if (r_credit >= w_price) begin
        w_credit_next = r_credit - w_price;
      end
    end else if (w_code == KEY_CANCEL) begin
      w_credit_next = 10'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credit    <= 10'd0;
      r_debounced <= 4'd0;
    end else if (w_press) begin
      r_credit    <= w_credit_next;
      r_debounced <= w_code;
    end
  end

  assign w_bcd     = bin_to_bcd(r_credit);
  assign debounced = r_debounced;
  assign D0        = seg_decode(w_bcd[3:0]);

`ifdef VM_BLANK_ZERO_EN
  assign D2 = (w_bcd[11:8] == 4'd0) ? SEG_BLANK : seg_decode(w_bcd[11:8]);
  assign D1 = (w_bcd[11:4] == 8'd0) ? SEG_BLANK : seg_decode(w_bcd[7:4]);
`else
  assign D2 = seg_decode(w_bcd[11:8]);
  assign D1 = seg_decode(w_bcd[7:4]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_vending_machine_core
// Brief   : Directed self-checking bench for vending_machine_core.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vending_machine_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] shift_col;
  logic [6:0] D0;
  logic [6:0] D1;
  logic [6:0] D2;
  logic [3:0] debounced;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vending_machine_core #(
    .DEBOUNCE_CYCLES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .shift_col(shift_col),
    .D0       (D0),
    .D1       (D1),
    .D2       (D2),
    .debounced(debounced)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic disp(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                      input logic [6:0] e0);
    chk({tag, "_D2"}, {1'b0, D2}, {1'b0, e2});
    chk({tag, "_D1"}, {1'b0, D1}, {1'b0, e1});
    chk({tag, "_D0"}, {1'b0, D0}, {1'b0, e0});
  endtask

  task automatic chk_dbn(input string tag, input logic [3:0] e);
    chk({tag, "_dbn"}, {4'h0, debounced}, {4'h0, e});
  endtask

  // Hold a key for 'hold' rising edges, release, let the update settle
  task automatic press(input logic [3:0] code, input int hold);
    logic [3:0] one;
    one = 4'b0001;
    @(negedge clk);
    shift_col = ~(one << code[3:2]);
    row       = ~(one << code[1:0]);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    row       = 4'hF;
    shift_col = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    row       = 4'hF;
    shift_col = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    disp("reset", 7'h40, 7'h40, 7'h40);
    chk_dbn("reset", 4'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    disp("idle", 7'h40, 7'h40, 7'h40);

    // Key 0 held: exactly one +5
    row       = 4'b1110;
    shift_col = 4'b1110;
    repeat (3) @(posedge clk);
    @(negedge clk);
    disp("coin5", 7'h40, 7'h40, 7'h12);
    chk_dbn("coin5", 4'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    disp("hold", 7'h40, 7'h40, 7'h12);
    row       = 4'hF;
    shift_col = 4'hF;
    repeat (2) @(posedge clk);

    press(4'd12, 2);
    disp("cancel1", 7'h40, 7'h40, 7'h40);
    chk_dbn("cancel1", 4'd12);

    // 100 + 100 + 25 = 225, then item 3 (100) -> 125
    press(4'd3, 2);
    press(4'd3, 2);
    press(4'd2, 2);
    disp("c225", 7'h24, 7'h24, 7'h12);
    press(4'd7, 2);
    disp("vend3", 7'h79, 7'h24, 7'h12);
    chk_dbn("vend3", 4'd7);

    // Credit 20 cannot buy item 0 (25)
    press(4'd12, 2);
    press(4'd1, 2);
    press(4'd1, 2);
    disp("c20", 7'h40, 7'h24, 7'h40);
    press(4'd4, 2);
    disp("short", 7'h40, 7'h24, 7'h40);
    chk_dbn("short", 4'd4);
    press(4'd12, 2);
    disp("cancel2", 7'h40, 7'h40, 7'h40);
    chk_dbn("cancel2", 4'd12);

    // Build 995 = 9*100 + 3*25 + 2*10, then coins that would exceed 999
    for (int i = 0; i < 9; i++) press(4'd3, 2);
    for (int i = 0; i < 3; i++) press(4'd2, 2);
    press(4'd1, 2);
    press(4'd1, 2);
    disp("c995", 7'h10, 7'h10, 7'h12);
    press(4'd0, 2);
    disp("rej5", 7'h10, 7'h10, 7'h12);
    press(4'd1, 2);
    disp("rej10", 7'h10, 7'h10, 7'h12);
    chk_dbn("rej10", 4'd1);

    // Asynchronous reset in the middle of a pending key 3
    @(negedge clk);
    row       = 4'b0111;
    shift_col = 4'b1110;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    disp("async", 7'h40, 7'h40, 7'h40);
    chk_dbn("async", 4'd0);
    @(negedge clk);
    row       = 4'hF;
    shift_col = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    disp("postrst", 7'h40, 7'h40, 7'h40);
    chk_dbn("postrst", 4'd0);

    // Exact price: 25 buys item 0, leaving 0
    press(4'd2, 2);
    press(4'd4, 2);
    disp("exact", 7'h40, 7'h40, 7'h40);
    chk_dbn("exact", 4'd4);

    press(4'd0, 2);
    disp("c5", 7'h40, 7'h40, 7'h12);
    chk_dbn("c5", 4'd0);

    // One-cycle glitch of code 6
    press(4'd6, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_dbn("glitch", 4'd0);
    disp("glitch", 7'h40, 7'h40, 7'h12);

    // Invalid column pattern held
    row       = 4'b1110;
    shift_col = 4'b1100;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk_dbn("invalid", 4'd0);
    disp("invalid", 7'h40, 7'h40, 7'h12);
    row       = 4'hF;
    shift_col = 4'hF;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vending_machine_core.md
# vending_machine_core

Keypad-driven vending-machine controller. It decodes a 4x4 active-low keypad matrix and debounces each key press into a single press event. It tracks customer credit from coin keys, vends items against a fixed price table, and drives three 7-segment digits showing the current credit in decimal. It sits between the board keypad/column scanner and the display pins.

## Interface
- DEBOUNCE_CYCLES, 2: consecutive cycles a valid key code must be stable before one press event fires (range 1..255).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- row  in  4  keypad row lines, active-low one-hot.
- shift_col  in  4  currently strobed keypad column, active-low one-hot, driven by the external scanner.
- D0  out  7  units digit, segments {g,f,e,d,c,b,a}, active-low.
- D1  out  7  tens digit, same encoding.
- D2  out  7  hundreds digit, same encoding.
- debounced  out  4  code of the last accepted key.

## Operation
- Key validity: both row and shift_col have exactly one 0 bit. Any other pattern is invalid.
- Key code: code = 4*col_idx + row_idx, where idx is the position of the 0 bit. For example, col 1110 / row 1110 gives code 0, and col 0111 / row 0111 gives code 15.
- Debounce: a stability counter increments each cycle the valid code equals the previous cycle's code. It restarts at 1 on a code change and at 0 on an invalid pattern.
  - The press event pulses for one cycle when the counter reaches DEBOUNCE_CYCLES.
  - There is no repeat while the key is held. Re-arming requires a code change or an invalid pattern.
- debounced loads the code on each press event and holds it otherwise.
- Credit is a binary register, 0..999. Actions on a press event:
  - codes 0/1/2/3: add 5/10/25/100. If the sum would exceed 999, the coin is rejected and credit is unchanged.
  - codes 4..11: select item 0..7 with prices 25, 50, 75, 100, 125, 150, 175, 200. If credit is at least the price, subtract the price. Otherwise credit is unchanged.
  - code 12: cancel, credit becomes 0.
  - codes 13..15: no effect on credit; still latched into debounced.
- Display: credit is converted combinationally to three BCD digits. D2 is the hundreds digit, D1 the tens, D0 the units.
  - Segment patterns 0..9: 40,79,24,30,19,12,02,78,00,10 (hex, active-low).
  - Blank is 7F.

## Timing
- Reset (asynchronous assert, synchronous release): credit 0, debounced 0, counter 0, event 0. D2..D0 all show 40 ("000"). With VM_BLANK_ZERO_EN defined, D2/D1 show 7F and D0 shows 40.
- A code first sampled at edge k fires its event at edge k+DEBOUNCE_CYCLES-1.
- debounced and credit update at the edge after the event. D0..D2 follow credit combinationally in the same cycle.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- Reset asserted mid-debounce discards the pending press.

## Configuration
- VM_BLANK_ZERO_EN:
  - Defined: leading-zero blanking. D2 is blank when hundreds = 0. D1 is blank when hundreds = 0 and tens = 0. D0 is never blanked.
  - Undefined: all three digits are always shown.

## Structure
- Package vm_pkg holds:
  - key-code constants (KEY_COIN5..KEY_CANCEL);
  - the coin value table and the 8-entry price table;
  - CREDIT_MAX = 999;
  - the segment pattern constants, including blank.
- One sub-module, kpd_debounce, parameterised by DEBOUNCE_CYCLES. It takes row/shift_col and outputs the code and the press pulse.
- BCD conversion and segment decode are functions in vm_pkg.

## Test plan
- Reset low then high, no key pressed → D2/D1/D0 = 40/40/40, debounced = 0.
- row/col 1110/1110 held 2 cycles → one event, credit 5, D0 = 12, debounced = 0. Holding 10 more cycles adds nothing.
- Keys 3, 3, 2 with a release between each (credit 225), then code 7 (item 3, price 100) → credit 125, D2/D1/D0 = 79/24/12.
- Credit 20, then code 4 (item 0, price 25) → credit stays 20, debounced = 4. Then code 12 → credit 0.
- Credit 995, then code 1 (+10) → credit stays 995.
- One-cycle pulse of 1101/1011 with DEBOUNCE_CYCLES = 2 → no event. Invalid pattern 1100/1110 held → no event, debounced unchanged.
